// File: rtl/l1_cache_pkg.sv
// rtl/l1_cache_pkg.sv - shared state enum, bus width defaults and address-field helpers for the L1 cache
package l1_cache_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WB,
    ST_FILL
  } state_e;

  // Helpers work on a 32-bit zero-extended word address; callers size-cast the result.
  function automatic logic [31:0] addr_offset(logic [31:0] addr, int off_w);
    return addr & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(logic [31:0] addr, int off_w, int idx_w);
    return (addr >> off_w) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(logic [31:0] addr, int off_w, int idx_w);
    return addr >> (off_w + idx_w);
  endfunction

endpackage

// File: rtl/l1_cache_ctrl_if.sv
// rtl/l1_cache_ctrl_if.sv - core request port and next-level memory bus bundle for l1_cache_ctrl
interface l1_cache_ctrl_if
  import l1_cache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [ADDR_W-1:0] core_addr;
  logic              core_read;
  logic              core_write;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // master: the core plus next-level memory; slave: the cache controller
  modport master (
    output core_addr, core_read, core_write, core_wdata, mem_rdata, mem_ready,
    input  core_rdata, core_stall, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport slave (
    input  core_addr, core_read, core_write, core_wdata, mem_rdata, mem_ready,
    output core_rdata, core_stall, mem_addr, mem_read, mem_write, mem_wdata
  );

endinterface

// File: rtl/l1_cache_array.sv
// rtl/l1_cache_array.sv - tag/valid/dirty/data storage, combinational read port, one synchronous write port
module l1_cache_array #(
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4,
  parameter int TAG_W  = 10,
  localparam int IDX_W = $clog2(LINES),
  localparam int OFF_W = $clog2(WORDS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IDX_W-1:0]             rd_idx,
  output logic                         rd_valid,
  output logic                         rd_dirty,
  output logic [TAG_W-1:0]             rd_tag,
  output logic [WORDS-1:0][DATA_W-1:0] rd_line,
  input  logic                         wr_en,
  input  logic                         wr_meta,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [OFF_W-1:0]             wr_off,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [TAG_W-1:0]             wr_tag,
  input  logic                         wr_dirty
);

  logic [LINES-1:0]               valid_q;
  logic [LINES-1:0]               dirty_q;
  logic [TAG_W-1:0]               tag_q  [LINES];
  logic [WORDS-1:0][DATA_W-1:0]   data_q [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  // A metadata write always marks the line valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en && wr_meta) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_idx][wr_off] <= wr_data;
      if (wr_meta) begin
        tag_q[wr_idx] <= wr_tag;
      end
    end
  end

endmodule

// File: rtl/l1_cache_ctrl.sv
// rtl/l1_cache_ctrl.sv - direct-mapped write-back write-allocate L1 cache controller with line-burst miss FSM
// Defining L1_CACHE_PERF_EN adds saturating hit_cnt/miss_cnt/wb_cnt outputs.
module l1_cache_ctrl
  import l1_cache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic           clk,
  input  logic           rst,
  l1_cache_ctrl_if.slave bus
`ifdef L1_CACHE_PERF_EN
  ,
  output logic [31:0]    hit_cnt,
  output logic [31:0]    miss_cnt,
  output logic [31:0]    wb_cnt
`endif
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  state_e                       state;
  logic [OFF_W-1:0]             beat;
  logic [OFF_W-1:0]             beat_nxt;
  logic                         mem_read_q;
  logic                         mem_write_q;
  logic [ADDR_W-1:0]            mem_addr_q;
  logic [DATA_W-1:0]            mem_wdata_q;

  logic [OFF_W-1:0]             req_off;
  logic [IDX_W-1:0]             req_idx;
  logic [TAG_W-1:0]             req_tag;
  logic                         req;
  logic                         hit;
  logic                         miss;
  logic                         last_beat;
  logic                         fill_done;

  logic                         rd_valid;
  logic                         rd_dirty;
  logic [TAG_W-1:0]             rd_tag;
  logic [WORDS-1:0][DATA_W-1:0] rd_line;
  logic                         wr_en;
  logic                         wr_meta;
  logic [OFF_W-1:0]             wr_off;
  logic [DATA_W-1:0]            wr_data;
  logic                         wr_dirty;

  assign req_off = OFF_W'(addr_offset(32'(bus.core_addr), OFF_W));
  assign req_idx = IDX_W'(addr_index(32'(bus.core_addr), OFF_W, IDX_W));
  assign req_tag = TAG_W'(addr_tag(32'(bus.core_addr), OFF_W, IDX_W));

  assign req       = bus.core_read || bus.core_write;
  assign hit       = rd_valid && (rd_tag == req_tag);
  assign miss      = (state == ST_IDLE) && req && !hit;
  assign beat_nxt  = beat + 1'b1;
  assign last_beat = (beat == LAST_BEAT);
  assign fill_done = (state == ST_FILL) && bus.mem_ready && last_beat;

  // Stall rises in the very cycle a miss is seen, before the FSM leaves IDLE.
  assign bus.core_stall = (state != ST_IDLE) || (req && !hit);
  assign bus.core_rdata = (state == ST_IDLE && bus.core_read && !bus.core_write && hit)
                          ? rd_line[req_off] : '0;

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  always_comb begin
    wr_en    = 1'b0;
    wr_meta  = 1'b0;
    wr_off   = req_off;
    wr_data  = bus.core_wdata;
    wr_dirty = 1'b0;
    if (state == ST_IDLE && bus.core_write && hit) begin
      wr_en    = 1'b1;
      wr_meta  = 1'b1;
      wr_dirty = 1'b1;
    end else if (state == ST_FILL && bus.mem_ready) begin
      wr_en   = 1'b1;
      wr_meta = last_beat;
      wr_off  = beat;
      wr_data = bus.mem_rdata;
    end
  end

  l1_cache_array #(
    .DATA_W (DATA_W),
    .LINES  (LINES),
    .WORDS  (WORDS),
    .TAG_W  (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_meta  (wr_meta),
    .wr_idx   (req_idx),
    .wr_off   (wr_off),
    .wr_data  (wr_data),
    .wr_tag   (req_tag),
    .wr_dirty (wr_dirty)
  );

  // The core holds its request during a miss, so req_idx/req_tag stay valid through WB and FILL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      beat        <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          beat <= '0;
          if (miss) begin
            if (rd_valid && rd_dirty) begin
              state       <= ST_WB;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {rd_tag, req_idx, {OFF_W{1'b0}}};
              mem_wdata_q <= rd_line[0];
            end else begin
              state      <= ST_FILL;
              mem_read_q <= 1'b1;
              mem_addr_q <= {req_tag, req_idx, {OFF_W{1'b0}}};
            end
          end
        end
        ST_WB: begin
          if (bus.mem_ready) begin
            if (last_beat) begin
              state       <= ST_FILL;
              beat        <= '0;
              mem_write_q <= 1'b0;
              mem_read_q  <= 1'b1;
              mem_addr_q  <= {req_tag, req_idx, {OFF_W{1'b0}}};
            end else begin
              beat        <= beat_nxt;
              mem_addr_q  <= {rd_tag, req_idx, beat_nxt};
              mem_wdata_q <= rd_line[beat_nxt];
            end
          end
        end
        ST_FILL: begin
          if (bus.mem_ready) begin
            if (last_beat) begin
              state      <= ST_IDLE;
              beat       <= '0;
              mem_read_q <= 1'b0;
            end else begin
              beat       <= beat_nxt;
              mem_addr_q <= {req_tag, req_idx, beat_nxt};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef L1_CACHE_PERF_EN
  logic filled;

  // filled marks the one IDLE cycle where the held request completes after its own fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
      filled   <= 1'b0;
    end else begin
      filled <= fill_done;
      if (state == ST_IDLE && req && hit && !filled && hit_cnt != '1) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (miss && miss_cnt != '1) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
      if (state == ST_WB && bus.mem_ready && last_beat && wb_cnt != '1) begin
        wb_cnt <= wb_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
